sequencer_contatore_base_2: RTL

- Start/done controller that sequences an N-bit counter built from a chain of base-2 counter elements. The elements are chained ripple-carry, with eu of stage i driving ei of stage i+1.
- On a start request the block clears the chain, latches a terminal count, and counts enabled ticks up to that value.
- It then signals completion with a soc/eoc handshake.
- It sits between a requesting control unit and the counting datapath, and is the only agent that drives the chain's ei and clear.

---
 rtl/sequencer_contatore_base_2_pkg.sv | 15 +
 rtl/sequencer_contatore_base_2_chain.sv | 34 +++
 rtl/sequencer_contatore_base_2.sv | 113 +++++++++++
 3 files changed

// File: rtl/sequencer_contatore_base_2_pkg.sv
// Shared definitions for the sequencer_contatore_base_2 slice.
// Contents:
//   N_DEFAULT - default counter width (number of chained base-2 elements)
//   state_t   - controller state encoding; 2'b11 is unused and recovers to IDLE
package sequencer_contatore_base_2_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/sequencer_contatore_base_2_chain.sv
// N chained base-2 counter elements with the ripple incrementer folded into
// a single adder. Element i's carry-out feeds element i+1's enable.
// Ports:
//   clock - system clock, rising edge
//   clear - synchronous clear, active-high, overrides ei
//   ei    - enable into stage 0 (increment by one this edge)
//   q     - element outputs, MSB = stage N-1
//   eu    - carry out of the last stage (all ones and enabled)
module contatore_base_2_chain
  import sequencer_contatore_base_2_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         ei,
  output logic [N-1:0] q,
  output logic         eu
);

  logic [N-1:0] r_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_q <= '0;
    end else begin
      r_q <= r_q + N'(ei);
    end
  end

  assign q  = r_q;
  assign eu = (&r_q) & ei;

endmodule

// File: rtl/sequencer_contatore_base_2.sv
// Start/done controller sequencing an N-bit base-2 counter chain.
// A start (soc=1 in IDLE) latches the terminal count, clears the chain and
// counts en ticks up to it; eoc then returns high and stays there until soc
// is released, so every new start needs a fresh soc rising edge.
// Ports:
//   clock  - system clock, rising edge
//   reset_ - synchronous reset, active-high, priority over everything
//   soc    - start of count (level, handshake with eoc)
//   limit  - terminal count, sampled only on the start edge
//   en     - count-enable tick while counting
//   eoc    - end of count: 1 idle/done, 0 busy
//   count  - current chain value
//   busy   - 1 only while counting
module sequencer_contatore_base_2
  import sequencer_contatore_base_2_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic [N-1:0] limit,
  input  logic         en,
  output logic         eoc,
  output logic [N-1:0] count,
  output logic         busy
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_limit;
  logic [N-1:0] w_q;
  logic         w_eu;
  logic         w_ei;
  logic         w_clear;
  logic         w_at_limit;
  logic         w_start;

  assign w_at_limit = (w_q == r_limit);
  assign w_start    = (r_state == ST_IDLE) && soc;

  // State register
  always_ff @(posedge clock) begin
    if (reset_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Terminal count is captured only on the start edge
  always_ff @(posedge clock) begin
    if (reset_) begin
      r_limit <= '0;
    end else if (w_start) begin
      r_limit <= limit;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = ST_IDLE;
    unique case (r_state)
      ST_IDLE:  w_state_nxt = soc ? ST_COUNT : ST_IDLE;
      // The compare is against the value already in the chain, so the edge
      // that observes count==limit moves to DONE without incrementing.
      ST_COUNT: w_state_nxt = w_at_limit ? ST_DONE : ST_COUNT;
      ST_DONE:  w_state_nxt = soc ? ST_DONE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / chain-control decode (Moore outputs from state only)
  always_comb begin
    eoc  = 1'b1;
    busy = 1'b0;
    w_ei = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        eoc  = 1'b1;
        busy = 1'b0;
      end
      ST_COUNT: begin
        eoc  = 1'b0;
        busy = 1'b1;
        // Stopping at the limit keeps the chain from ever reaching its carry-out
        w_ei = en & ~w_at_limit;
      end
      ST_DONE: begin
        eoc  = 1'b1;
        busy = 1'b0;
      end
      default: begin
        eoc  = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  // Reset and start both zero the chain
  assign w_clear = reset_ | w_start;

  contatore_base_2_chain #(.N(N)) u_chain (
    .clock (clock),
    .clear (w_clear),
    .ei    (w_ei),
    .q     (w_q),
    .eu    (w_eu)
  );

  assign count = w_q;

endmodule
